// File: rtl/dmd_scan_ctrl_if.sv
// dmd_scan_ctrl_if
//   Bundles the control, write and display signals of the DMD row scanner.
//   master : the host side; drives enable, buffer writes and swap requests,
//            and observes the display outputs.
//   slave  : the scanner itself (dmd_scan_ctrl).
//   Signals:
//     enable       scanning allowed while high
//     wr_en        write wr_data into back-buffer row wr_row
//     wr_row       back-buffer row address (4 bits)
//     wr_data      column pattern, bit n drives column n (16 bits)
//     swap_req     one-cycle pulse requesting a buffer swap at the frame boundary
//     swap_pending swap requested but not yet performed
//     frame_done   one-cycle pulse on the last display cycle of row 15
//     DMD_CLR      display blanking, active-high
//     DMD_CLK      column latch strobe, active-high
//     dmd_seg      selected row index (4 bits)
//     dmd_column   column data for the selected row (16 bits)
interface dmd_scan_ctrl_if;
    logic        enable;
    logic        wr_en;
    logic [3:0]  wr_row;
    logic [15:0] wr_data;
    logic        swap_req;
    logic        swap_pending;
    logic        frame_done;
    logic        DMD_CLR;
    logic        DMD_CLK;
    logic [3:0]  dmd_seg;
    logic [15:0] dmd_column;

    modport master (
        output enable, wr_en, wr_row, wr_data, swap_req,
        input  swap_pending, frame_done, DMD_CLR, DMD_CLK, dmd_seg, dmd_column
    );

    modport slave (
        input  enable, wr_en, wr_row, wr_data, swap_req,
        output swap_pending, frame_done, DMD_CLR, DMD_CLK, dmd_seg, dmd_column
    );
endinterface

// File: rtl/dmd_scan_ctrl.sv
// dmd_scan_ctrl
//   Row scanner for a 16x16 dot-matrix display with double-buffered frame
//   memory. Each row runs BLANK (CLR_CYCLES) -> LOAD (1) -> LATCH (CLK_CYCLES)
//   -> SHOW (HOLD_CYCLES). The front buffer is scanned, the back buffer is
//   written; a requested swap takes effect at the end of row 15.
//   All cycle-count parameters must be at least 1.
//   Ports:
//     CLK    system clock, rising edge
//     RESET  asynchronous, active-low reset
//     bus    dmd_scan_ctrl_if.slave (control, write and display signals)
module dmd_scan_ctrl #(
    parameter int unsigned CLR_CYCLES  = 2,
    parameter int unsigned CLK_CYCLES  = 2,
    parameter int unsigned HOLD_CYCLES = 64
) (
    input  logic           CLK,
    input  logic           RESET,
    dmd_scan_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        LOAD,
        LATCH,
        SHOW
    } state_t;

    state_t                  state;
    logic [15:0]             cnt;
    logic [3:0]              row;
    logic                    front_sel;
    logic [1:0][15:0][15:0]  fb;

    logic                    swap_pending_q;
    logic                    frame_done_q;
    logic                    clr_q;
    logic                    clk_q;
    logic [3:0]              seg_q;
    logic [15:0]             col_q;

    assign bus.swap_pending = swap_pending_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.DMD_CLR      = clr_q;
    assign bus.DMD_CLK      = clk_q;
    assign bus.dmd_seg      = seg_q;
    assign bus.dmd_column   = col_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= IDLE;
            cnt            <= '0;
            row            <= '0;
            front_sel      <= 1'b0;
            fb             <= '0;
            swap_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            clr_q          <= 1'b1;
            clk_q          <= 1'b0;
            seg_q          <= '0;
            col_q          <= '0;
        end else begin
            // Writes go to the current back buffer; on a swap edge that is
            // the buffer about to become front.
            if (bus.wr_en)
                fb[~front_sel][bus.wr_row] <= bus.wr_data;

            // frame_done is only high on the last SHOW cycle of row 15, so
            // a swap can never happen from IDLE.
            if (frame_done_q && swap_pending_q) begin
                front_sel      <= ~front_sel;
                swap_pending_q <= bus.swap_req;
            end else if (bus.swap_req) begin
                swap_pending_q <= 1'b1;
            end

            frame_done_q <= 1'b0;

            case (state)
                IDLE: begin
                    clr_q <= 1'b1;
                    clk_q <= 1'b0;
                    seg_q <= '0;
                    col_q <= '0;
                    row   <= '0;
                    cnt   <= '0;
                    if (bus.enable)
                        state <= BLANK;
                end

                BLANK: begin
                    if (32'(cnt) == CLR_CYCLES - 1) begin
                        state <= LOAD;
                        cnt   <= '0;
                        col_q <= fb[front_sel][row];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                LOAD: begin
                    state <= LATCH;
                    cnt   <= '0;
                    clr_q <= 1'b0;
                    clk_q <= 1'b1;
                end

                LATCH: begin
                    if (32'(cnt) == CLK_CYCLES - 1) begin
                        state        <= SHOW;
                        cnt          <= '0;
                        clk_q        <= 1'b0;
                        frame_done_q <= (HOLD_CYCLES == 1) && (row == 4'd15);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                SHOW: begin
                    if (32'(cnt) == HOLD_CYCLES - 1) begin
                        cnt   <= '0;
                        clr_q <= 1'b1;
                        if (bus.enable) begin
                            state <= BLANK;
                            row   <= row + 4'd1;
                            seg_q <= row + 4'd1;
                        end else begin
                            state <= IDLE;
                            row   <= '0;
                            seg_q <= '0;
                            col_q <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                        // Registered one cycle early so the pulse lines up
                        // with the final SHOW cycle of row 15.
                        frame_done_q <= (32'(cnt) + 32'd2 == HOLD_CYCLES) &&
                                        (row == 4'd15);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmd_scan_ctrl.sv
// tb_dmd_scan_ctrl
//   Directed bench for dmd_scan_ctrl with default parameters
//   (row period 69 cycles, frame 1104 cycles).
module tb_dmd_scan_ctrl;

    logic CLK = 1'b0;
    logic RESET;

    dmd_scan_ctrl_if bus ();

    dmd_scan_ctrl #(
        .CLR_CYCLES  (2),
        .CLK_CYCLES  (2),
        .HOLD_CYCLES (64)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          fd_last = 0;
    int          fd_prev = 0;
    bit          fd_wr_arm   = 1'b0;
    bit          fd_swap_arm = 1'b0;
    logic [15:0] exp_cols [16];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; sampling and driving happen 1 time unit after the edge.
    // Pulse inputs last exactly one cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        bus.swap_req = 1'b0;
        bus.wr_en    = 1'b0;
        cyc++;
    endtask

    // Follows one row from its latch strobe to the end of its SHOW phase.
    task automatic scan_row(input string tag, input logic [3:0] exp_seg,
                            input logic [15:0] exp_col, input int exp_fd,
                            input int exp_wait, input bit drop_en);
        int          waited;
        int          n;
        int          fd_cnt;
        bit          stable;
        logic [3:0]  seg0;
        logic [15:0] col0;
        waited = 0;
        while (bus.DMD_CLK !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        check_val({tag, "_wait"}, waited, exp_wait);
        if (waited >= 300)
            return;
        check_val({tag, "_seg"}, bus.dmd_seg, exp_seg);
        check_val({tag, "_col"}, bus.dmd_column, exp_col);
        check_val({tag, "_clr"}, bus.DMD_CLR, 1'b0);
        tick();
        check_val({tag, "_clk2"}, bus.DMD_CLK, 1'b1);
        tick();
        check_val({tag, "_clkoff"}, bus.DMD_CLK, 1'b0);
        if (drop_en)
            bus.enable = 1'b0;
        n      = 0;
        fd_cnt = 0;
        stable = 1'b1;
        seg0   = bus.dmd_seg;
        col0   = bus.dmd_column;
        while (bus.DMD_CLR === 1'b0 && n < 300) begin
            if (bus.dmd_seg !== seg0 || bus.dmd_column !== col0 ||
                bus.DMD_CLK !== 1'b0)
                stable = 1'b0;
            if (bus.frame_done === 1'b1) begin
                fd_cnt++;
                fd_prev = fd_last;
                fd_last = cyc;
                if (fd_wr_arm) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_row  = 4'd0;
                    bus.wr_data = 16'h00FF;
                    fd_wr_arm   = 1'b0;
                end
                if (fd_swap_arm) begin
                    bus.swap_req = 1'b1;
                    fd_swap_arm  = 1'b0;
                end
            end
            tick();
            n++;
        end
        check_val({tag, "_show"}, n, 64);
        check_val({tag, "_stable"}, stable, 1'b1);
        check_val({tag, "_fd"}, fd_cnt, exp_fd);
    endtask

    task automatic scan_frame(input string tag, input int first_wait,
                              input logic [15:0] req_rows);
        for (int r = 0; r < 16; r++) begin
            if (req_rows[r])
                bus.swap_req = 1'b1;
            scan_row($sformatf("%s_r%0d", tag, r), 4'(r), exp_cols[r],
                     (r == 15) ? 1 : 0, (r == 0) ? first_wait : 3, 1'b0);
            if (req_rows[r] && r != 15)
                check_val($sformatf("%s_r%0d_pend", tag, r),
                          bus.swap_pending, 1'b1);
        end
    endtask

    initial begin
        int clk_hi;
        int fd_hi;
        int waited;

        RESET        = 1'b1;
        bus.enable   = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_row   = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        #2 RESET = 1'b0;
        tick();
        tick();

        check_val("rst_clr",  bus.DMD_CLR, 1'b1);
        check_val("rst_clk",  bus.DMD_CLK, 1'b0);
        check_val("rst_seg",  bus.dmd_seg, 4'd0);
        check_val("rst_col",  bus.dmd_column, 16'd0);
        check_val("rst_fd",   bus.frame_done, 1'b0);
        check_val("rst_pend", bus.swap_pending, 1'b0);

        RESET = 1'b1;
        tick();
        check_val("idle_clr", bus.DMD_CLR, 1'b1);
        check_val("idle_clk", bus.DMD_CLK, 1'b0);

        // Frame 1: all-zero buffers, row stepping and timing.
        foreach (exp_cols[i]) exp_cols[i] = '0;
        bus.enable = 1'b1;
        scan_frame("f1", 4, 16'h0000);

        // Frame 2: back-buffer write plus swap request; front stays zero.
        bus.wr_en   = 1'b1;
        bus.wr_row  = 4'd3;
        bus.wr_data = 16'hA5A5;
        scan_frame("f2", 3, 16'h0001);
        check_val("frame_len", fd_last - fd_prev, 1104);
        check_val("f2_pend_clr", bus.swap_pending, 1'b0);

        // Frame 3: swapped content; two requests; write on the swap cycle.
        exp_cols[3] = 16'hA5A5;
        fd_wr_arm   = 1'b1;
        scan_frame("f3", 3, 16'h0006);
        check_val("f3_pend_clr", bus.swap_pending, 1'b0);

        // Frame 4: write landed in new front; request on the swap cycle.
        exp_cols[0] = 16'h00FF;
        exp_cols[3] = 16'h0000;
        fd_swap_arm = 1'b1;
        scan_frame("f4", 3, 16'h0002);
        check_val("f4_pend_kept", bus.swap_pending, 1'b1);

        // Frame 5: enable dropped during SHOW of row 7.
        exp_cols[0] = 16'h0000;
        exp_cols[3] = 16'hA5A5;
        for (int r = 0; r < 8; r++)
            scan_row($sformatf("f5_r%0d", r), 4'(r), exp_cols[r], 0, 3, r == 7);
        check_val("drop_clr", bus.DMD_CLR, 1'b1);
        check_val("drop_seg", bus.dmd_seg, 4'd0);
        check_val("drop_col", bus.dmd_column, 16'd0);
        clk_hi = 0;
        fd_hi  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.DMD_CLK === 1'b1) clk_hi++;
            if (bus.frame_done === 1'b1) fd_hi++;
            tick();
        end
        check_val("idle_noclk", clk_hi, 0);
        check_val("idle_nofd", fd_hi, 0);
        check_val("idle_pend", bus.swap_pending, 1'b1);

        // Re-enable: restart at row 0, no swap happened while idle.
        bus.enable = 1'b1;
        for (int r = 0; r < 4; r++)
            scan_row($sformatf("re_r%0d", r), 4'(r), exp_cols[r], 0,
                     (r == 0) ? 4 : 3, 1'b0);

        // Reset during LATCH of row 4.
        waited = 0;
        while (bus.DMD_CLK !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        check_val("latch4_wait", waited, 3);
        check_val("latch4_seg", bus.dmd_seg, 4'd4);
        RESET = 1'b0;
        #1;
        check_val("ar_clk",  bus.DMD_CLK, 1'b0);
        check_val("ar_clr",  bus.DMD_CLR, 1'b1);
        check_val("ar_seg",  bus.dmd_seg, 4'd0);
        check_val("ar_col",  bus.dmd_column, 16'd0);
        check_val("ar_fd",   bus.frame_done, 1'b0);
        check_val("ar_pend", bus.swap_pending, 1'b0);
        tick();
        check_val("ar_hold_clk", bus.DMD_CLK, 1'b0);
        tick();
        RESET = 1'b1;

        // Both buffers must read back as zero after reset.
        foreach (exp_cols[i]) exp_cols[i] = '0;
        scan_frame("f6", 4, 16'h0001);
        check_val("f6_pend_clr", bus.swap_pending, 1'b0);
        for (int r = 0; r < 4; r++)
            scan_row($sformatf("f7_r%0d", r), 4'(r), 16'h0000, 0, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
